// File: rtl/vga_scanout.sv
// vga_scanout: 640x480@60 VGA timing and pixel pipeline from CLOCK_50.
// A divide-by-2 pixel enable gives the 25 MHz pixel rate. Read coordinates
// go to the framebuffer, the returned RGB332 byte is expanded to 8:8:8, and
// RGB, syncs and blank leave through one register stage so they stay aligned.
// No handshakes: the framebuffer is a fixed 1-cycle-latency read port, and
// its data is sampled at the second CLOCK_50 edge after the address changes.
module vga_scanout #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic [7:0]  pixel_data,
  output logic [10:0] rd_x,
  output logic [10:0] rd_y,
  output logic [7:0]  VGA_R,
  output logic [7:0]  VGA_G,
  output logic [7:0]  VGA_B,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_N,
  output logic        VGA_SYNC_N,
  output logic        VGA_CLK,
  output logic        frame_start,
  output logic        vblank
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic        pix_en;
  logic [10:0] h_cnt;
  logic [10:0] v_cnt;
  logic [10:0] h_nxt;
  logic [10:0] v_nxt;
  logic        h_wrap;
  logic        v_wrap;
  logic        cur_active;
  logic        nxt_active;

  assign h_wrap     = (h_cnt == H_LAST);
  assign v_wrap     = (v_cnt == V_LAST);
  assign cur_active = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign nxt_active = (h_nxt < H_ACT) && (v_nxt < V_ACT);
  assign VGA_SYNC_N = 1'b0;

  // Next counter position: h wraps at end of line, v advances on h wrap.
  always_comb begin
    h_nxt = h_cnt + 11'd1;
    v_nxt = v_cnt;
    if (h_wrap) begin
      h_nxt = 11'd0;
      v_nxt = v_wrap ? 11'd0 : v_cnt + 11'd1;
    end
  end

  // Pixel enable toggles every cycle; an edge with pix_en high is a tick.
  always_ff @(posedge CLOCK_50) begin
    if (!reset) pix_en <= 1'b0;
    else        pix_en <= ~pix_en;
  end

  // Raster counters advance once per tick.
  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      h_cnt <= 11'd0;
      v_cnt <= 11'd0;
    end else if (pix_en) begin
      h_cnt <= h_nxt;
      v_cnt <= v_nxt;
    end
  end

  // Read address tracks the counters inside the visible area, else parks at 0.
  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      rd_x <= 11'd0;
      rd_y <= 11'd0;
    end else if (pix_en) begin
      rd_x <= nxt_active ? h_nxt : 11'd0;
      rd_y <= nxt_active ? v_nxt : 11'd0;
    end
  end

  // Output stage: the pre-update counters describe the pixel whose data is now on pixel_data.
  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      VGA_R       <= 8'd0;
      VGA_G       <= 8'd0;
      VGA_B       <= 8'd0;
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      VGA_BLANK_N <= 1'b0;
      vblank      <= 1'b0;
    end else if (pix_en) begin
      VGA_R       <= cur_active ? {pixel_data[7:5], pixel_data[7:5], pixel_data[7:6]} : 8'd0;
      VGA_G       <= cur_active ? {pixel_data[4:2], pixel_data[4:2], pixel_data[4:3]} : 8'd0;
      VGA_B       <= cur_active ? {4{pixel_data[1:0]}} : 8'd0;
      VGA_HS      <= !((h_cnt >= HS_START) && (h_cnt < HS_END));
      VGA_VS      <= !((v_cnt >= VS_START) && (v_cnt < VS_END));
      VGA_BLANK_N <= cur_active;
      vblank      <= (v_cnt >= V_ACT);
    end
  end

  // DAC clock rises at the non-tick edge, centred in the output data window.
  always_ff @(posedge CLOCK_50) begin
    if (!reset) VGA_CLK <= 1'b0;
    else        VGA_CLK <= ~pix_en;
  end

  // One-cycle pulse after the tick that wraps the raster back to (0,0).
  always_ff @(posedge CLOCK_50) begin
    if (!reset) frame_start <= 1'b0;
    else        frame_start <= pix_en && h_wrap && v_wrap;
  end

endmodule
